// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
// The result struct carries a full 64-bit immediate; RV32 users keep the low half.
package imm_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_J    = 3'd3,
        FMT_U    = 3'd4,
        FMT_CSR  = 3'd5,
        FMT_CSRI = 3'd6,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        logic [4:0]          zimm;
        imm_fmt_e            fmt;
        logic                illegal;
    } imm_res_t;

    localparam imm_res_t RES_EMPTY = '{imm: '0, zimm: '0, fmt: FMT_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-driven immediate decoder.
// Immediates are built at 64 bits; sign extension from inst[31] makes the low half correct for RV32.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] i_inst,
    output imm_res_t    o_res
);

    logic [2:0]  w_funct3;
    logic [63:0] w_imm_i;
    logic [63:0] w_imm_s;
    logic [63:0] w_imm_b;
    logic [63:0] w_imm_j;
    logic [63:0] w_imm_u;
    logic [63:0] w_imm_csr;

    assign w_funct3  = i_inst[14:12];
    assign w_imm_i   = {{52{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s   = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b   = {{52{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_j   = {{44{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign w_imm_u   = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_imm_csr = {52'b0, i_inst[31:20]};

    always_comb begin
        o_res = RES_EMPTY;
        if (i_inst[1:0] != 2'b11) begin
            o_res.illegal = 1'b1;
        end else begin
            case (i_inst[6:0])
                OP_LOAD, OP_JALR, OP_FENCE: begin
                    o_res.fmt = FMT_I;
                    o_res.imm = w_imm_i;
                end
                OP_IMM: begin
                    o_res.fmt = FMT_I;
                    // funct3 001/101 are the shifts: the immediate is the raw shamt
                    if (w_funct3[1:0] == 2'b01) begin
                        if (XLEN == 64) begin
                            o_res.imm = {58'b0, i_inst[25:20]};
                        end else begin
                            o_res.imm     = {59'b0, i_inst[24:20]};
                            o_res.illegal = i_inst[25];
                        end
                    end else begin
                        o_res.imm = w_imm_i;
                    end
                end
                OP_IMM32: begin
                    if (XLEN == 64) begin
                        o_res.fmt = FMT_I;
                        o_res.imm = w_imm_i;
                    end else begin
                        o_res.illegal = 1'b1;
                    end
                end
                OP_STORE: begin
                    o_res.fmt = FMT_S;
                    o_res.imm = w_imm_s;
                end
                OP_BRANCH: begin
                    o_res.fmt = FMT_B;
                    o_res.imm = w_imm_b;
                end
                OP_JAL: begin
                    o_res.fmt = FMT_J;
                    o_res.imm = w_imm_j;
                end
                OP_LUI, OP_AUIPC: begin
                    o_res.fmt = FMT_U;
                    o_res.imm = w_imm_u;
                end
                OP_SYSTEM: begin
                    if (w_funct3 != 3'b000) begin
                        o_res.imm = w_imm_csr;
                        if (w_funct3[2]) begin
                            o_res.fmt  = FMT_CSRI;
                            o_res.zimm = i_inst[19:15];
                        end else begin
                            o_res.fmt = FMT_CSR;
                        end
                    end
                end
                OP_REG: begin
                    o_res.fmt = FMT_NONE;
                end
                OP_REG32: begin
                    o_res.illegal = (XLEN != 64);
                end
                default: begin
                    o_res.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Handshaked immediate-generation stage: decoder feeding an OUT register plus one skid entry.
// in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_zimm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    imm_res_t         w_dec;
    imm_res_t         r_out;
    imm_res_t         r_skid;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_out_v;
    logic             r_skid_v;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_out_adv;
    logic             w_pop;
    logic             w_unused_imm;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_inst (in_inst),
        .o_res  (w_dec)
    );

    assign in_ready  = !r_skid_v;
    assign w_accept  = in_valid && !r_skid_v;
    assign w_out_adv = !r_out_v || out_ready;
    assign w_pop     = r_out_v && out_ready;

    // Skid is only ever filled while OUT is stalled, so it always drains into OUT first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v    <= 1'b0;
            r_out      <= RES_EMPTY;
            r_out_tag  <= '0;
            r_skid_v   <= 1'b0;
            r_skid     <= RES_EMPTY;
            r_skid_tag <= '0;
        end else if (flush) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_out_adv) begin
            if (r_skid_v) begin
                r_out     <= r_skid;
                r_out_tag <= r_skid_tag;
                r_out_v   <= 1'b1;
                r_skid_v  <= 1'b0;
            end else if (w_accept) begin
                r_out     <= w_dec;
                r_out_tag <= in_tag;
                r_out_v   <= 1'b1;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_dec;
            r_skid_tag <= in_tag;
            r_skid_v   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_pop && r_out.illegal && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_unused_imm = ^r_out.imm;

    assign out_valid   = r_out_v;
    assign out_imm     = r_out.imm[XLEN-1:0];
    assign out_zimm    = r_out.zimm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;
    assign out_tag     = r_out_tag;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 instance (2-bit counter) and an RV64 instance share one stimulus stream.
// Directed vector table and handshake sequences, then random traffic against a FIFO-level reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_tag;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm, a_tag;
    logic [4:0]  a_zimm;
    logic [2:0]  a_fmt;
    logic [1:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    logic [4:0]  b_zimm;
    logic [2:0]  b_fmt;
    logic [15:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm), .out_zimm(a_zimm),
        .out_fmt(a_fmt), .out_illegal(a_ill), .out_tag(a_tag), .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm), .out_zimm(b_zimm),
        .out_fmt(b_fmt), .out_illegal(b_ill), .out_tag(b_tag), .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  zimm;
        logic [2:0]  fmt;
        logic        ill;
    } ref_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic        ill32;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
        logic        ill64;
        logic [4:0]  zimm;
    } vec_t;

    // Reference decode straight from the format rules, using signed arithmetic on the fields.
    function automatic ref_t refDecode(input logic [31:0] inst, input bit is64);
        ref_t        r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        longint      v;
        opc    = inst[6:0];
        f3     = inst[14:12];
        r.imm  = 64'd0;
        r.zimm = 5'd0;
        r.fmt  = 3'd7;
        r.ill  = 1'b0;
        v      = 0;
        if (inst[1:0] != 2'b11) begin
            r.ill = 1'b1;
        end else if (opc == 7'h03 || opc == 7'h13 || opc == 7'h67 || opc == 7'h0F ||
                     (opc == 7'h1B && is64)) begin
            r.fmt = 3'd0;
            v     = 64'($signed(inst[31:20]));
            r.imm = v;
            if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                if (is64) begin
                    r.imm = 64'(inst[25:20]);
                end else begin
                    r.imm = 64'(inst[24:20]);
                    r.ill = inst[25];
                end
            end
        end else if (opc == 7'h23) begin
            r.fmt = 3'd1;
            v     = 64'($signed({inst[31:25], inst[11:7]}));
            r.imm = v;
        end else if (opc == 7'h63) begin
            r.fmt = 3'd2;
            v     = 64'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            r.imm = v;
        end else if (opc == 7'h6F) begin
            r.fmt = 3'd3;
            v     = 64'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            r.imm = v;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            r.fmt = 3'd4;
            v     = 64'($signed({inst[31:12], 12'h000}));
            r.imm = v;
        end else if (opc == 7'h73) begin
            if (f3 != 3'd0) begin
                r.imm = 64'(inst[31:20]);
                r.fmt = f3[2] ? 3'd6 : 3'd5;
                if (f3[2]) r.zimm = inst[19:15];
            end
        end else if (opc == 7'h33 || (opc == 7'h3B && is64)) begin
            r.fmt = 3'd7;
        end else begin
            r.ill = 1'b1;
        end
        if (!is64) r.imm = {32'd0, r.imm[31:0]};
        return r;
    endfunction

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [0:12];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h67,
                7'h37, 7'h17, 7'h73, 7'h0F, 7'h33, 7'h3B};
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        return {w[31:7], ops[$urandom_range(0, 12)]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " a.valid"}, 64'(a_out_valid), 64'd0);
        checkOutput({name, " b.valid"}, 64'(b_out_valid), 64'd0);
        checkOutput({name, " a.ready"}, 64'(a_in_ready), 64'd1);
        checkOutput({name, " b.ready"}, 64'(b_in_ready), 64'd1);
        checkOutput({name, " a.imm"}, 64'(a_imm), 64'd0);
        checkOutput({name, " b.imm"}, b_imm, 64'd0);
        checkOutput({name, " a.zimm"}, 64'(a_zimm), 64'd0);
        checkOutput({name, " b.zimm"}, 64'(b_zimm), 64'd0);
        checkOutput({name, " a.fmt"}, 64'(a_fmt), 64'd7);
        checkOutput({name, " b.fmt"}, 64'(b_fmt), 64'd7);
        checkOutput({name, " a.ill"}, 64'(a_ill), 64'd0);
        checkOutput({name, " b.ill"}, 64'(b_ill), 64'd0);
        checkOutput({name, " a.tag"}, 64'(a_tag), 64'd0);
        checkOutput({name, " b.tag"}, 64'(b_tag), 64'd0);
        checkOutput({name, " a.cnt"}, 64'(a_cnt), 64'd0);
        checkOutput({name, " b.cnt"}, 64'(b_cnt), 64'd0);
    endtask

    task automatic checkEntry(input string name, input logic [31:0] inst, input logic [31:0] tag);
        ref_t e32;
        ref_t e64;
        e32 = refDecode(inst, 1'b0);
        e64 = refDecode(inst, 1'b1);
        checkOutput({name, " a.imm"}, 64'(a_imm), e32.imm);
        checkOutput({name, " a.zimm"}, 64'(a_zimm), 64'(e32.zimm));
        checkOutput({name, " a.fmt"}, 64'(a_fmt), 64'(e32.fmt));
        checkOutput({name, " a.ill"}, 64'(a_ill), 64'(e32.ill));
        checkOutput({name, " a.tag"}, 64'(a_tag), 64'(tag));
        checkOutput({name, " b.imm"}, b_imm, e64.imm);
        checkOutput({name, " b.zimm"}, 64'(b_zimm), 64'(e64.zimm));
        checkOutput({name, " b.fmt"}, 64'(b_fmt), 64'(e64.fmt));
        checkOutput({name, " b.ill"}, 64'(b_ill), 64'(e64.ill));
        checkOutput({name, " b.tag"}, 64'(b_tag), 64'(tag));
    endtask

    task automatic checkFlow(input string name, input logic expValid, input logic expReady);
        checkOutput({name, " a.valid"}, 64'(a_out_valid), 64'(expValid));
        checkOutput({name, " b.valid"}, 64'(b_out_valid), 64'(expValid));
        checkOutput({name, " a.ready"}, 64'(a_in_ready), 64'(expReady));
        checkOutput({name, " b.ready"}, 64'(b_in_ready), 64'(expReady));
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [0:15];
        logic [31:0] qInst [$];
        logic [31:0] qTag  [$];
        int          mCnt32;
        int          mCnt64;
        ref_t        f32;
        ref_t        f64;
        bit          pop;
        bit          push;

        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd0};
        vecs[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0, 5'd0};
        vecs[2]  = '{32'h3002D073, 3'd6, 32'h00000300, 1'b0, 3'd6, 64'h0000000000000300, 1'b0, 5'd5};
        vecs[3]  = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0, 5'd0};
        vecs[4]  = '{32'h03F09093, 3'd0, 32'h0000001F, 1'b1, 3'd0, 64'h000000000000003F, 1'b0, 5'd0};
        vecs[5]  = '{32'h00000000, 3'd7, 32'h00000000, 1'b1, 3'd7, 64'h0000000000000000, 1'b1, 5'd0};
        vecs[6]  = '{32'h00112623, 3'd1, 32'h0000000C, 1'b0, 3'd1, 64'h000000000000000C, 1'b0, 5'd0};
        vecs[7]  = '{32'hFF9FF0EF, 3'd3, 32'hFFFFFFF8, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 1'b0, 5'd0};
        vecs[8]  = '{32'h30009073, 3'd5, 32'h00000300, 1'b0, 3'd5, 64'h0000000000000300, 1'b0, 5'd0};
        vecs[9]  = '{32'h00000073, 3'd7, 32'h00000000, 1'b0, 3'd7, 64'h0000000000000000, 1'b0, 5'd0};
        vecs[10] = '{32'h002081B3, 3'd7, 32'h00000000, 1'b0, 3'd7, 64'h0000000000000000, 1'b0, 5'd0};
        vecs[11] = '{32'hFFF0009B, 3'd7, 32'h00000000, 1'b1, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd0};
        vecs[12] = '{32'h0000007F, 3'd7, 32'h00000000, 1'b1, 3'd7, 64'h0000000000000000, 1'b1, 5'd0};
        vecs[13] = '{32'h0FF0000F, 3'd0, 32'h000000FF, 1'b0, 3'd0, 64'h00000000000000FF, 1'b0, 5'd0};
        vecs[14] = '{32'h4030D093, 3'd0, 32'h00000003, 1'b0, 3'd0, 64'h0000000000000003, 1'b0, 5'd0};
        vecs[15] = '{32'h00001117, 3'd4, 32'h00001000, 1'b0, 3'd4, 64'h0000000000001000, 1'b0, 5'd0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #8;
        checkReset("por");
        #4 rst_n = 1'b1;

        // Directed vector table, one instruction per cycle with downstream always ready
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, vecs[i].inst, 32'(i + 1), 1'b1, 1'b0);
            step();
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d a.valid", i), 64'(a_out_valid), 64'd1);
            checkOutput($sformatf("vec%0d b.valid", i), 64'(b_out_valid), 64'd1);
            checkOutput($sformatf("vec%0d a.fmt", i), 64'(a_fmt), 64'(vecs[i].fmt32));
            checkOutput($sformatf("vec%0d a.imm", i), 64'(a_imm), 64'(vecs[i].imm32));
            checkOutput($sformatf("vec%0d a.ill", i), 64'(a_ill), 64'(vecs[i].ill32));
            checkOutput($sformatf("vec%0d a.zimm", i), 64'(a_zimm), 64'(vecs[i].zimm));
            checkOutput($sformatf("vec%0d b.fmt", i), 64'(b_fmt), 64'(vecs[i].fmt64));
            checkOutput($sformatf("vec%0d b.imm", i), b_imm, vecs[i].imm64);
            checkOutput($sformatf("vec%0d b.ill", i), 64'(b_ill), 64'(vecs[i].ill64));
            checkOutput($sformatf("vec%0d b.zimm", i), 64'(b_zimm), 64'(vecs[i].zimm));
            checkOutput($sformatf("vec%0d a.tag", i), 64'(a_tag), 64'(i + 1));
        end
        step();
        checkFlow("drain", 1'b0, 1'b1);

        // Backpressure: three back-to-back offers with downstream stalled
        applyStimulus(1'b1, ADDI, 32'd1, 1'b0, 1'b0);
        step();
        checkFlow("bp1", 1'b1, 1'b1);
        checkOutput("bp1 a.tag", 64'(a_tag), 64'd1);
        applyStimulus(1'b1, ADDI, 32'd2, 1'b0, 1'b0);
        step();
        checkFlow("bp2", 1'b1, 1'b0);
        checkOutput("bp2 a.tag", 64'(a_tag), 64'd1);
        applyStimulus(1'b1, ADDI, 32'd3, 1'b0, 1'b0);
        step();
        checkFlow("bp3", 1'b1, 1'b0);
        checkOutput("bp3 b.tag", 64'(b_tag), 64'd1);
        applyStimulus(1'b1, ADDI, 32'd3, 1'b1, 1'b0);
        step();
        checkFlow("bp4", 1'b1, 1'b1);
        checkOutput("bp4 a.tag", 64'(a_tag), 64'd2);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkFlow("bp5", 1'b1, 1'b1);
        checkOutput("bp5 a.tag", 64'(a_tag), 64'd3);
        checkOutput("bp5 b.tag", 64'(b_tag), 64'd3);
        step();
        checkFlow("bp6", 1'b0, 1'b1);

        // Flush with both entries full and an input offered
        applyStimulus(1'b1, ADDI, 32'd10, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, ADDI, 32'd11, 1'b0, 1'b0);
        step();
        checkFlow("fl.full", 1'b1, 1'b0);
        applyStimulus(1'b1, ADDI, 32'd12, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkFlow("fl1", 1'b0, 1'b1);
        step();
        checkFlow("fl1.after", 1'b0, 1'b1);
        // Flush while the stage could accept: the offered input must still be dropped
        applyStimulus(1'b1, ADDI, 32'd13, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, ADDI, 32'd14, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkFlow("fl2", 1'b0, 1'b1);
        step();
        checkFlow("fl2.after", 1'b0, 1'b1);

        // Illegal counter: fresh reset, five illegal instructions back to back
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h00000000, 32'(20 + i), 1'b1, 1'b0);
            step();
            if (i == 0) begin
                checkOutput("cnt0 a.fmt", 64'(a_fmt), 64'd7);
                checkOutput("cnt0 a.ill", 64'(a_ill), 64'd1);
                checkOutput("cnt0 a.cnt", 64'(a_cnt), 64'd0);
            end
            if (i == 1) begin
                checkOutput("cnt1 a.cnt", 64'(a_cnt), 64'd1);
                checkOutput("cnt1 b.cnt", 64'(b_cnt), 64'd1);
            end
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("cntsat a.cnt", 64'(a_cnt), 64'd3);
        checkOutput("cntsat b.cnt", 64'(b_cnt), 64'd5);

        // Asynchronous reset while a result is held
        applyStimulus(1'b1, ADDI, 32'h55, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("midrst pre.valid", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 checkReset("midrst");
        #2 rst_n = 1'b1;
        step();

        // Random traffic against a two-deep FIFO model
        mCnt32 = 0;
        mCnt64 = 0;
        for (int c = 0; c < 600; c++) begin
            checkFlow($sformatf("rnd%0d", c), qInst.size() > 0, qInst.size() < 2);
            if (qInst.size() > 0) checkEntry($sformatf("rnd%0d", c), qInst[0], qTag[0]);
            checkOutput($sformatf("rnd%0d a.cnt", c), 64'(a_cnt), 64'(mCnt32));
            checkOutput($sformatf("rnd%0d b.cnt", c), 64'(b_cnt), 64'(mCnt64));
            applyStimulus($urandom_range(0, 3) != 0, randInst(), 32'(c + 1000),
                          $urandom_range(0, 2) != 0, 1'b0);
            pop  = (qInst.size() > 0) && out_ready;
            push = in_valid && (qInst.size() < 2);
            if (pop) begin
                f32 = refDecode(qInst[0], 1'b0);
                f64 = refDecode(qInst[0], 1'b1);
                if (f32.ill && mCnt32 < 3) mCnt32++;
                if (f64.ill && mCnt64 < 65535) mCnt64++;
                void'(qInst.pop_front());
                void'(qTag.pop_front());
            end
            if (push) begin
                qInst.push_back(in_inst);
                qTag.push_back(in_tag);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
